// File: rtl/pc_jump_unit_if.sv
// pc_jump_unit_if: decoder <-> jump unit bundle carrying branch requests and the PC load port.
interface pc_jump_unit_if #(
  parameter int PC_WIDTH    = 8,
  parameter int STACK_DEPTH = 4
);
  localparam int DW = $clog2(STACK_DEPTH) + 1;
  logic [PC_WIDTH-1:0] pc;
  logic [PC_WIDTH-1:0] target;
  logic                jmp;
  logic                jz;
  logic                zero;
  logic                call;
  logic                ret;
  logic [PC_WIDTH-1:0] counteradress;
  logic                wr_en;
  logic [DW-1:0]       depth;
  logic                ovf;
  logic                unf;
  modport master (
    output pc, target, jmp, jz, zero, call, ret,
    input  counteradress, wr_en, depth, ovf, unf
  );
  modport slave (
    input  pc, target, jmp, jz, zero, call, ret,
    output counteradress, wr_en, depth, ovf, unf
  );
endinterface

// File: rtl/pc_jump_unit.sv
// pc_jump_unit: registered jump/call/return writer for the program counter load port.
// Return stack, call and ret are compiled in only when PC_JUMP_CALL_STACK_EN is defined.
module pc_jump_unit #(
  parameter int PC_WIDTH    = 8,
  parameter int STACK_DEPTH = 4
) (
  input logic             clk,
  input logic             res_n,
  pc_jump_unit_if.slave   bus
);
  localparam int DW = $clog2(STACK_DEPTH) + 1;
  logic [PC_WIDTH-1:0] addr_q, addr_d;
  logic                wr_q, wr_d, br;
  assign bus.counteradress = addr_q;
  assign bus.wr_en         = wr_q;
`ifdef PC_JUMP_CALL_STACK_EN
  localparam int PW = $clog2(STACK_DEPTH);
  logic [PC_WIDTH-1:0] stack [STACK_DEPTH];
  logic [DW-1:0]       depth_q, depth_d;
  logic                ovf_q, ovf_d, unf_q, unf_d, push, pop;
  // depth doubles as the stack pointer: top entry lives at depth-1
  always_comb begin
    pop     = bus.ret && depth_q != '0;
    push    = !bus.ret && bus.call && depth_q != DW'(STACK_DEPTH);
    br      = !bus.ret && !bus.call && (bus.jmp || (bus.jz && bus.zero));
    wr_d    = pop || push || br;
    addr_d  = pop ? stack[PW'(depth_q - DW'(1))] : (push || br) ? bus.target : addr_q;
    depth_d = pop ? depth_q - DW'(1) : push ? depth_q + DW'(1) : depth_q;
    ovf_d   = ovf_q || (!bus.ret && bus.call && !push);
    unf_d   = unf_q || (bus.ret && !pop);
  end
  always_ff @(posedge clk)
    if (push) stack[PW'(depth_q)] <= bus.pc + PC_WIDTH'(1);
  always_ff @(posedge clk or negedge res_n)
    if (!res_n) begin
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  assign bus.depth = depth_q;
  assign bus.ovf   = ovf_q;
  assign bus.unf   = unf_q;
`else
  always_comb begin
    br     = bus.jmp || (bus.jz && bus.zero);
    wr_d   = br;
    addr_d = br ? bus.target : addr_q;
  end
  assign bus.depth = DW'(0);
  assign bus.ovf   = 1'b0;
  assign bus.unf   = 1'b0;
`endif
  always_ff @(posedge clk or negedge res_n)
    if (!res_n) begin
      addr_q <= '0;
      wr_q   <= 1'b0;
    end else begin
      addr_q <= addr_d;
      wr_q   <= wr_d;
    end
endmodule

// File: tb/tb_pc_jump_unit.sv
// tb_pc_jump_unit: directed-vector bench for pc_jump_unit; stack scenarios follow PC_JUMP_CALL_STACK_EN.
module tb_pc_jump_unit;
  logic clk = 1'b0;
  logic res_n = 1'b0;
  int   vec = 0;
  int   miss = 0;
  pc_jump_unit_if #(.PC_WIDTH(8), .STACK_DEPTH(4)) bus ();
  pc_jump_unit #(.PC_WIDTH(8), .STACK_DEPTH(4)) dut (.clk(clk), .res_n(res_n), .bus(bus));
  always #5 clk = ~clk;
  // observed word: {wr_en, counteradress, depth, ovf, unf}
  logic [13:0] obs;
  assign obs = {bus.wr_en, bus.counteradress, bus.depth, bus.ovf, bus.unf};

  task automatic drive(input logic r, input logic c, input logic j, input logic z,
                       input logic zf, input logic [7:0] p, input logic [7:0] t);
    bus.ret = r; bus.call = c; bus.jmp = j; bus.jz = z; bus.zero = zf; bus.pc = p; bus.target = t;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    drive(0, 0, 0, 0, 0, 8'h00, 8'h00);
    res_n = 1'b0;
    #9;
    if (obs !== 14'h0) begin miss++; $display("FAIL reset_hold got %h want %h", obs, 14'h0); end
    vec++;
    #1 res_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick;
      if (obs !== 14'h0) begin miss++; $display("FAIL reset_idle%0d got %h want %h", i, obs, 14'h0); end
      vec++;
    end
  endtask

  task automatic test_jmp;
    drive(0, 0, 1, 0, 0, 8'h00, 8'd32);
    tick;
    drive(0, 0, 0, 0, 0, 8'h00, 8'h00);
    if (obs !== {1'b1, 8'd32, 3'd0, 2'b00}) begin miss++; $display("FAIL jmp_pulse got %h want %h", obs, {1'b1, 8'd32, 3'd0, 2'b00}); end
    vec++;
    tick;
    if (obs !== {1'b0, 8'd32, 3'd0, 2'b00}) begin miss++; $display("FAIL jmp_hold got %h want %h", obs, {1'b0, 8'd32, 3'd0, 2'b00}); end
    vec++;
  endtask

  task automatic test_jz;
    drive(0, 0, 0, 1, 0, 8'h00, 8'h40);
    tick;
    if (obs !== {1'b0, 8'd32, 3'd0, 2'b00}) begin miss++; $display("FAIL jz_not_taken got %h want %h", obs, {1'b0, 8'd32, 3'd0, 2'b00}); end
    vec++;
    drive(0, 0, 0, 1, 1, 8'h00, 8'h40);
    tick;
    drive(0, 0, 0, 0, 0, 8'h00, 8'h00);
    if (obs !== {1'b1, 8'h40, 3'd0, 2'b00}) begin miss++; $display("FAIL jz_taken got %h want %h", obs, {1'b1, 8'h40, 3'd0, 2'b00}); end
    vec++;
    tick;
    if (obs !== {1'b0, 8'h40, 3'd0, 2'b00}) begin miss++; $display("FAIL jz_after got %h want %h", obs, {1'b0, 8'h40, 3'd0, 2'b00}); end
    vec++;
  endtask

  task automatic test_back_to_back;
    drive(0, 0, 1, 0, 0, 8'h00, 8'h01);
    tick;
    if (obs[13:5] !== {1'b1, 8'h01}) begin miss++; $display("FAIL b2b_0 got %h want %h", obs[13:5], {1'b1, 8'h01}); end
    vec++;
    drive(0, 0, 1, 0, 0, 8'h00, 8'h02);
    tick;
    if (obs[13:5] !== {1'b1, 8'h02}) begin miss++; $display("FAIL b2b_1 got %h want %h", obs[13:5], {1'b1, 8'h02}); end
    vec++;
    drive(0, 0, 0, 1, 1, 8'h00, 8'h03);
    tick;
    drive(0, 0, 0, 0, 0, 8'h00, 8'h00);
    if (obs[13:5] !== {1'b1, 8'h03}) begin miss++; $display("FAIL b2b_2 got %h want %h", obs[13:5], {1'b1, 8'h03}); end
    vec++;
    tick;
    if (obs[13:5] !== {1'b0, 8'h03}) begin miss++; $display("FAIL b2b_end got %h want %h", obs[13:5], {1'b0, 8'h03}); end
    vec++;
  endtask

`ifdef PC_JUMP_CALL_STACK_EN
  task automatic test_call_ret;
    drive(0, 1, 0, 0, 0, 8'h10, 8'h80);
    tick;
    if (obs !== {1'b1, 8'h80, 3'd1, 2'b00}) begin miss++; $display("FAIL call got %h want %h", obs, {1'b1, 8'h80, 3'd1, 2'b00}); end
    vec++;
    drive(1, 0, 0, 0, 0, 8'h80, 8'h00);
    tick;
    if (obs !== {1'b1, 8'h11, 3'd0, 2'b00}) begin miss++; $display("FAIL ret got %h want %h", obs, {1'b1, 8'h11, 3'd0, 2'b00}); end
    vec++;
    drive(0, 1, 0, 0, 0, 8'hFF, 8'h22);
    tick;
    if (obs !== {1'b1, 8'h22, 3'd1, 2'b00}) begin miss++; $display("FAIL call_ff got %h want %h", obs, {1'b1, 8'h22, 3'd1, 2'b00}); end
    vec++;
    drive(1, 0, 0, 0, 0, 8'h22, 8'h00);
    tick;
    drive(0, 0, 0, 0, 0, 8'h00, 8'h00);
    if (obs !== {1'b1, 8'h00, 3'd0, 2'b00}) begin miss++; $display("FAIL ret_wrap got %h want %h", obs, {1'b1, 8'h00, 3'd0, 2'b00}); end
    vec++;
  endtask

  task automatic test_priority;
    drive(0, 1, 0, 0, 0, 8'h05, 8'h50);
    tick;
    if (obs !== {1'b1, 8'h50, 3'd1, 2'b00}) begin miss++; $display("FAIL prio_setup got %h want %h", obs, {1'b1, 8'h50, 3'd1, 2'b00}); end
    vec++;
    drive(1, 1, 1, 1, 1, 8'h09, 8'h77);
    tick;
    drive(0, 0, 0, 0, 0, 8'h00, 8'h00);
    if (obs !== {1'b1, 8'h06, 3'd0, 2'b00}) begin miss++; $display("FAIL prio_ret got %h want %h", obs, {1'b1, 8'h06, 3'd0, 2'b00}); end
    vec++;
  endtask

  task automatic test_overflow;
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 0, 0, 0, 8'(i * 16), 8'(8'hA0 + i));
      tick;
      if (obs !== {1'b1, 8'(8'hA0 + i), 3'(i + 1), 2'b00}) begin miss++; $display("FAIL push%0d got %h want %h", i, obs, {1'b1, 8'(8'hA0 + i), 3'(i + 1), 2'b00}); end
      vec++;
    end
    drive(0, 1, 0, 0, 0, 8'h70, 8'hEE);
    tick;
    if (obs !== {1'b0, 8'hA3, 3'd4, 2'b10}) begin miss++; $display("FAIL ovf got %h want %h", obs, {1'b0, 8'hA3, 3'd4, 2'b10}); end
    vec++;
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 0, 0, 8'h00, 8'h00);
      tick;
      if (obs !== {1'b1, 8'(8'h31 - 16 * i), 3'(3 - i), 2'b10}) begin miss++; $display("FAIL pop%0d got %h want %h", i, obs, {1'b1, 8'(8'h31 - 16 * i), 3'(3 - i), 2'b10}); end
      vec++;
    end
    tick;
    drive(0, 0, 0, 0, 0, 8'h00, 8'h00);
    if (obs !== {1'b0, 8'h01, 3'd0, 2'b11}) begin miss++; $display("FAIL unf got %h want %h", obs, {1'b0, 8'h01, 3'd0, 2'b11}); end
    vec++;
  endtask
`else
  task automatic test_stack_disabled;
    drive(0, 1, 0, 0, 0, 8'h10, 8'h80);
    tick;
    if (obs !== {1'b0, 8'h03, 3'd0, 2'b00}) begin miss++; $display("FAIL call_ignored got %h want %h", obs, {1'b0, 8'h03, 3'd0, 2'b00}); end
    vec++;
    drive(1, 0, 0, 0, 0, 8'h10, 8'h80);
    tick;
    if (obs !== {1'b0, 8'h03, 3'd0, 2'b00}) begin miss++; $display("FAIL ret_ignored got %h want %h", obs, {1'b0, 8'h03, 3'd0, 2'b00}); end
    vec++;
    drive(1, 1, 1, 0, 0, 8'h10, 8'h55);
    tick;
    if (obs !== {1'b1, 8'h55, 3'd0, 2'b00}) begin miss++; $display("FAIL jmp_over_call got %h want %h", obs, {1'b1, 8'h55, 3'd0, 2'b00}); end
    vec++;
    drive(1, 1, 0, 1, 1, 8'h10, 8'h66);
    tick;
    drive(0, 0, 0, 0, 0, 8'h00, 8'h00);
    if (obs !== {1'b1, 8'h66, 3'd0, 2'b00}) begin miss++; $display("FAIL jz_over_ret got %h want %h", obs, {1'b1, 8'h66, 3'd0, 2'b00}); end
    vec++;
  endtask
`endif

  task automatic test_reset_midop;
    drive(0, 0, 1, 0, 0, 8'h00, 8'h99);
    res_n = 1'b0;
    #1;
    if (obs !== 14'h0) begin miss++; $display("FAIL async_clear got %h want %h", obs, 14'h0); end
    vec++;
    tick;
    if (obs !== 14'h0) begin miss++; $display("FAIL reset_jmp got %h want %h", obs, 14'h0); end
    vec++;
    @(negedge clk);
    res_n = 1'b1;
    drive(0, 0, 0, 0, 0, 8'h00, 8'h00);
    tick;
    if (obs !== 14'h0) begin miss++; $display("FAIL post_reset got %h want %h", obs, 14'h0); end
    vec++;
  endtask

  initial begin
    test_reset;
    test_jmp;
    test_jz;
    test_back_to_back;
`ifdef PC_JUMP_CALL_STACK_EN
    test_call_ret;
    test_priority;
    test_overflow;
`else
    test_stack_disabled;
`endif
    test_reset_midop;
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
